// File: rtl/timer_ctrl.sv
// Sequencer for the 17-bit ripple-counter timer: clears/enables the counter, filters its
// asynchronous output into a stable sample and raises wakeup/irq on a compare match.
module timer_ctrl #(
  parameter int unsigned WIDTH       = 17,
  parameter int unsigned CLR_CYCLES  = 2,
  parameter int unsigned MATCH_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   cfg_wr,
  input  logic [WIDTH-1:0]       cfg_cmp,
  input  logic                   cfg_periodic,
  input  logic                   irq_ack,
  input  logic [WIDTH-1:0]       cnt_val,
  output logic                   cnt_clr,
  output logic                   cnt_en,
  output logic                   wakeup,
  output logic                   irq,
  output logic                   overrun,
  output logic                   busy,
  output logic [2:0]             state,
  output logic [MATCH_CNT_W-1:0] match_cnt
);

  localparam int unsigned CW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam logic [CW-1:0] ClrLast = CW'(CLR_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StClear = 3'd1,
    StRun   = 3'd2,
    StMatch = 3'd3,
    StDone  = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic [WIDTH-1:0]       cmp_act_q, cmp_act_d;
  logic [WIDTH-1:0]       cmp_pend_q, cmp_pend_d;
  logic                   per_act_q, per_act_d;
  logic                   per_pend_q, per_pend_d;
  logic [WIDTH-1:0]       s1_q, s1_d;
  logic [WIDTH-1:0]       s2_q, s2_d;
  logic [CW-1:0]          clr_cnt_q, clr_cnt_d;
  logic                   irq_q, irq_d;
  logic                   overrun_q, overrun_d;
  logic [MATCH_CNT_W-1:0] match_cnt_q, match_cnt_d;

  logic stable;
  logic in_match;

  // Two equal consecutive samples mean the ripple counter had settled.
  assign stable   = (s1_q == s2_q);
  assign in_match = (state_q == StMatch);

  always_comb begin
    state_d     = state_q;
    cmp_act_d   = cmp_act_q;
    cmp_pend_d  = cmp_pend_q;
    per_act_d   = per_act_q;
    per_pend_d  = per_pend_q;
    s1_d        = s1_q;
    s2_d        = s2_q;
    clr_cnt_d   = '0;
    irq_d       = in_match | (irq_q & ~irq_ack);
    overrun_d   = (in_match & irq_q) | (overrun_q & ~irq_ack);
    match_cnt_d = in_match ? match_cnt_q + MATCH_CNT_W'(1) : match_cnt_q;

    case (state_q)
      StIdle:  if (start) state_d = StClear;
      StClear: if (clr_cnt_q == ClrLast) state_d = StRun;
      StRun:   if (stable && (s2_q >= cmp_act_q)) state_d = StMatch;
      StMatch: state_d = per_act_q ? StClear : StDone;
      StDone:  if (start) state_d = StClear;
      default: state_d = StIdle;
    endcase
    if (stop && (state_q != StIdle)) state_d = StIdle;

    if (state_q == StClear) begin
      s1_d = '0;
      s2_d = '0;
    end else if (state_q == StRun) begin
      s1_d = cnt_val;
      s2_d = s1_q;
    end

    if ((state_q == StClear) && (state_d == StClear)) clr_cnt_d = clr_cnt_q + CW'(1);

    if (cfg_wr) begin
      cmp_pend_d = cfg_cmp;
      per_pend_d = cfg_periodic;
      if ((state_q == StIdle) || (state_q == StDone)) begin
        cmp_act_d = cfg_cmp;
        per_act_d = cfg_periodic;
      end
    end

    // Shadow config takes effect at the start of each period.
    if ((state_d == StClear) && (state_q != StClear)) begin
      cmp_act_d = cmp_pend_d;
      per_act_d = per_pend_d;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q     <= StIdle;
      cmp_act_q   <= '1;
      cmp_pend_q  <= '1;
      per_act_q   <= 1'b0;
      per_pend_q  <= 1'b0;
      s1_q        <= '0;
      s2_q        <= '0;
      clr_cnt_q   <= '0;
      irq_q       <= 1'b0;
      overrun_q   <= 1'b0;
      match_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cmp_act_q   <= cmp_act_d;
      cmp_pend_q  <= cmp_pend_d;
      per_act_q   <= per_act_d;
      per_pend_q  <= per_pend_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      clr_cnt_q   <= clr_cnt_d;
      irq_q       <= irq_d;
      overrun_q   <= overrun_d;
      match_cnt_q <= match_cnt_d;
    end
  end

  // Counter controls decode from state only, so reset drops cnt_clr immediately.
  assign cnt_clr   = (state_q == StRun) || (state_q == StMatch) || (state_q == StDone);
  assign cnt_en    = (state_q == StRun) || (state_q == StMatch);
  assign wakeup    = in_match;
  assign busy      = (state_q == StClear) || (state_q == StRun) || (state_q == StMatch);
  assign state     = state_q;
  assign irq       = irq_q;
  assign overrun   = overrun_q;
  assign match_cnt = match_cnt_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl with a divide-by-4 ripple-counter model.
module tb_timer_ctrl;
  localparam int unsigned W = 17;

  logic         clk = 1'b0;
  logic         clr = 1'b1;
  logic         start = 1'b0, stop = 1'b0, cfg_wr = 1'b0, cfg_periodic = 1'b0, irq_ack = 1'b0;
  logic [W-1:0] cfg_cmp = '0;
  logic [W-1:0] cnt_val;
  logic         cnt_clr, cnt_en, wakeup, irq, overrun, busy;
  logic [2:0]   state;
  logic [7:0]   match_cnt;

  logic [W-1:0] mdl_cnt;
  logic [1:0]   mdl_div;
  logic         glitch = 1'b0;
  logic         ovr = 1'b0;
  logic [W-1:0] ovr_val = '0;

  int total = 0;
  int bad = 0;

  timer_ctrl #(.WIDTH(W), .CLR_CYCLES(2), .MATCH_CNT_W(8)) dut (
    .clk          (clk),
    .clr          (clr),
    .start        (start),
    .stop         (stop),
    .cfg_wr       (cfg_wr),
    .cfg_cmp      (cfg_cmp),
    .cfg_periodic (cfg_periodic),
    .irq_ack      (irq_ack),
    .cnt_val      (cnt_val),
    .cnt_clr      (cnt_clr),
    .cnt_en       (cnt_en),
    .wakeup       (wakeup),
    .irq          (irq),
    .overrun      (overrun),
    .busy         (busy),
    .state        (state),
    .match_cnt    (match_cnt)
  );

  always #5 clk = ~clk;

  // Ripple counter model: async clear, one increment every 4 enabled clocks.
  always @(posedge clk or negedge cnt_clr) begin
    if (!cnt_clr) begin
      mdl_cnt <= '0;
      mdl_div <= '0;
    end else if (cnt_en) begin
      if (mdl_div == 2'd3) begin
        mdl_div <= '0;
        mdl_cnt <= mdl_cnt + 1'b1;
      end else begin
        mdl_div <= mdl_div + 1'b1;
      end
    end
  end

  assign cnt_val = ovr ? ovr_val : (glitch ? 17'd31 : mdl_cnt);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [W-1:0] cmp, input logic per);
    cfg_cmp = cmp;
    cfg_periodic = per;
    cfg_wr = 1'b1;
    tick;
    cfg_wr = 1'b0;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task automatic test_reset;
    #1 clr = 1'b0;
    #2;
    total++;
    if ({state, cnt_clr, cnt_en, wakeup} !== 6'b0) begin
      bad++;
      $display("FAIL reset_ctrl got=%b want=%b", {state, cnt_clr, cnt_en, wakeup}, 6'b0);
    end
    total++;
    if ({irq, overrun, busy, match_cnt} !== 11'b0) begin
      bad++;
      $display("FAIL reset_flags got=%b want=%b", {irq, overrun, busy, match_cnt}, 11'b0);
    end
    #4 clr = 1'b1;
    tick;
    total++;
    if (state !== 3'd0) begin bad++; $display("FAIL idle_hold got=%0d want=0", state); end
  endtask

  task automatic test_oneshot;
    int k = -1, w = -1, nw = 0;
    cfg(17'd10, 1'b0);
    pulse_start;
    for (int i = 0; i < 80; i++) begin
      if (k < 0 && cnt_val >= 17'd10) k = i;
      if (wakeup) begin nw++; if (w < 0) w = i; end
      tick;
    end
    total++;
    if (nw !== 1) begin bad++; $display("FAIL oneshot_count got=%0d want=1", nw); end
    total++;
    if (k !== 42 || w !== 45) begin
      bad++;
      $display("FAIL oneshot_timing got k=%0d w=%0d want k=42 w=45", k, w);
    end
    total++;
    if ({state, cnt_en, cnt_clr, busy} !== {3'd4, 1'b0, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL oneshot_done got=%b want=%b", {state, cnt_en, cnt_clr, busy}, 6'b100010);
    end
    total++;
    if (irq !== 1'b1 || match_cnt !== 8'd1) begin
      bad++;
      $display("FAIL oneshot_irq got irq=%b mc=%0d want irq=1 mc=1", irq, match_cnt);
    end
  endtask

  task automatic test_async_reset;
    pulse_start;
    tick;
    tick;
    tick;
    total++;
    if (state !== 3'd2) begin bad++; $display("FAIL pre_reset_run got=%0d want=2", state); end
    #2 clr = 1'b0;
    #1;
    total++;
    if ({state, cnt_clr, cnt_en, busy} !== 6'b0) begin
      bad++;
      $display("FAIL async_reset_ctrl got=%b want=%b", {state, cnt_clr, cnt_en, busy}, 6'b0);
    end
    total++;
    if (irq !== 1'b0 || match_cnt !== 8'd0) begin
      bad++;
      $display("FAIL async_reset_flags got irq=%b mc=%0d want 0 0", irq, match_cnt);
    end
    #2 clr = 1'b1;
  endtask

  task automatic test_periodic_glitch;
    int nw = 0, k = -1, ws0 = -1, ws1 = -1, k0 = -1, k1 = -1;
    cfg(17'd5, 1'b1);
    pulse_start;
    for (int i = 0; i < 120 && nw < 2; i++) begin
      glitch = (state == 3'd2) && (mdl_cnt == 17'd1 || mdl_cnt == 17'd3) && (mdl_div == 2'd1);
      if (nw == 1 && i == ws0 + 1) begin
        total++;
        if (irq !== 1'b1 || overrun !== 1'b0) begin
          bad++;
          $display("FAIL first_irq got irq=%b ovr=%b want 1 0", irq, overrun);
        end
      end
      if (k < 0 && !glitch && state == 3'd2 && mdl_cnt >= 17'd5) k = i;
      if (wakeup) begin
        if (nw == 0) begin ws0 = i; k0 = k; end else begin ws1 = i; k1 = k; end
        nw++;
        k = -1;
      end
      tick;
    end
    glitch = 1'b0;
    total++;
    if (nw !== 2 || ws0 !== 25 || ws1 !== 51) begin
      bad++;
      $display("FAIL periodic_times got n=%0d w0=%0d w1=%0d want 2 25 51", nw, ws0, ws1);
    end
    total++;
    if (ws0 - k0 !== 3 || ws1 - k1 !== 3) begin
      bad++;
      $display("FAIL periodic_latency got %0d %0d want 3 3", ws0 - k0, ws1 - k1);
    end
    total++;
    if (irq !== 1'b1 || overrun !== 1'b1) begin
      bad++;
      $display("FAIL overrun_set got irq=%b ovr=%b want 1 1", irq, overrun);
    end
    irq_ack = 1'b1;
    tick;
    irq_ack = 1'b0;
    total++;
    if (irq !== 1'b0 || overrun !== 1'b0) begin
      bad++;
      $display("FAIL irq_ack got irq=%b ovr=%b want 0 0", irq, overrun);
    end
    stop = 1'b1;
    tick;
    stop = 1'b0;
    total++;
    if (state !== 3'd0) begin bad++; $display("FAIL stop_idle got=%0d want=0", state); end
  endtask

  task automatic test_shadow;
    int nw = 0, ws0 = -1, ws1 = -1;
    cfg(17'd100, 1'b1);
    pulse_start;
    for (int i = 0; i < 600 && nw < 2; i++) begin
      if (i == 5) begin
        cfg_cmp = 17'd3;
        cfg_periodic = 1'b1;
        cfg_wr = 1'b1;
      end else begin
        cfg_wr = 1'b0;
      end
      if (wakeup) begin
        if (nw == 0) ws0 = i; else ws1 = i;
        nw++;
      end
      tick;
    end
    cfg_wr = 1'b0;
    total++;
    if (ws0 !== 405 || ws1 !== 423) begin
      bad++;
      $display("FAIL shadow_cfg got w0=%0d w1=%0d want 405 423", ws0, ws1);
    end
    stop = 1'b1;
    tick;
    stop = 1'b0;
  endtask

  task automatic test_conflicts_cmp0;
    logic [2:0] exp_st [5];
    exp_st = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4};
    irq_ack = 1'b1;
    tick;
    irq_ack = 1'b0;
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL pre_ack got=%b want=0", irq); end
    cfg(17'd1000, 1'b0);
    pulse_start;
    tick;
    tick;
    start = 1'b1;
    stop = 1'b1;
    tick;
    start = 1'b0;
    stop = 1'b0;
    total++;
    if (state !== 3'd0 || cnt_en !== 1'b0) begin
      bad++;
      $display("FAIL start_stop got st=%0d en=%b want 0 0", state, cnt_en);
    end
    cfg(17'd0, 1'b0);
    pulse_start;
    for (int j = 0; j < 5; j++) begin
      total++;
      if (state !== exp_st[j] || wakeup !== (j == 3)) begin
        bad++;
        $display("FAIL cmp0_seq[%0d] got st=%0d wk=%b want st=%0d wk=%b",
                 j, state, wakeup, exp_st[j], (j == 3));
      end
      irq_ack = (j == 3);
      tick;
      irq_ack = 1'b0;
    end
    total++;
    if (irq !== 1'b1 || overrun !== 1'b0) begin
      bad++;
      $display("FAIL set_beats_ack got irq=%b ovr=%b want 1 0", irq, overrun);
    end
  endtask

  task automatic test_full_count;
    int nw = 0;
    ovr = 1'b1;
    ovr_val = 17'h1FFFE;
    cfg(17'h1FFFF, 1'b0);
    pulse_start;
    for (int i = 0; i < 10; i++) begin
      if (wakeup) nw++;
      tick;
    end
    total++;
    if (nw !== 0 || state !== 3'd2) begin
      bad++;
      $display("FAIL below_full got n=%0d st=%0d want 0 2", nw, state);
    end
    ovr_val = 17'h1FFFF;
    for (int j = 0; j < 4; j++) begin
      total++;
      if (wakeup !== (j == 3)) begin
        bad++;
        $display("FAIL full_count[%0d] got wk=%b want %b", j, wakeup, (j == 3));
      end
      tick;
    end
    ovr = 1'b0;
    total++;
    if (state !== 3'd4) begin bad++; $display("FAIL full_done got=%0d want=4", state); end
  endtask

  task automatic test_wrap;
    int n = 0;
    bit done = 1'b0;
    #2 clr = 1'b0;
    #1;
    total++;
    if (match_cnt !== 8'd0) begin bad++; $display("FAIL wrap_clr got=%0d want=0", match_cnt); end
    #1 clr = 1'b1;
    cfg(17'd0, 1'b1);
    pulse_start;
    for (int i = 0; i < 2000 && !done; i++) begin
      if (wakeup) begin
        n++;
        if (n == 255) begin
          total++;
          if (match_cnt !== 8'd254) begin
            bad++;
            $display("FAIL wrap_254 got=%0d want=254", match_cnt);
          end
        end
        if (n == 256) begin
          stop = 1'b1;
          done = 1'b1;
        end
      end
      tick;
      stop = 1'b0;
    end
    total++;
    if (n !== 256 || match_cnt !== 8'd0 || state !== 3'd0) begin
      bad++;
      $display("FAIL wrap got n=%0d mc=%0d st=%0d want 256 0 0", n, match_cnt, state);
    end
  endtask

  initial begin
    test_reset;
    test_oneshot;
    test_async_reset;
    test_periodic_glitch;
    test_shadow;
    test_conflicts_cmp0;
    test_full_count;
    test_wrap;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule

// File: doc/timer_ctrl.md
# timer_ctrl

Synchronous sequencer for the 17-bit asynchronous ripple-counter timer. It clears and enables the counter, filters the counter's rippling output into a stable sample, and compares that sample against a programmed compare value. On a match it raises a one-cycle wakeup pulse and a sticky interrupt, then stops (one-shot) or restarts the count (periodic). It sits between the configuration/register logic and the counter macro.

## Interface
Parameters:
- WIDTH, 17, counter and compare width
- CLR_CYCLES, 2, cycles the counter clear is held active (≥1)
- MATCH_CNT_W, 8, width of the match counter

Ports:
- clk  in  1  system clock; all state changes on rising edge
- clr  in  1  reset, asynchronous, active-low
- start  in  1  level-sampled command: begin or restart timing
- stop  in  1  level-sampled command: abort and return to IDLE
- cfg_wr  in  1  write strobe for cfg_cmp / cfg_periodic
- cfg_cmp  in  WIDTH  compare value
- cfg_periodic  in  1  1 = auto-restart after match, 0 = one-shot
- irq_ack  in  1  clears irq and overrun
- cnt_val  in  WIDTH  raw counter output, asynchronous to clk
- cnt_clr  out  1  active-low clear to the counter
- cnt_en  out  1  counter clock enable
- wakeup  out  1  one-cycle pulse per match
- irq  out  1  sticky match flag
- overrun  out  1  sticky: match occurred while irq still set
- busy  out  1  state is CLEAR, RUN or MATCH
- state  out  3  IDLE=0, CLEAR=1, RUN=2, MATCH=3, DONE=4
- match_cnt  out  MATCH_CNT_W  matches since reset, wraps

## Operation
- Registers: cmp_act, per_act (active), cmp_pend, per_pend (pending), s1, s2 (samples), clear counter, match_cnt.
- cfg_wr in IDLE or DONE writes pending and active together. In CLEAR/RUN/MATCH it writes pending only; pending is copied to active on every entry into CLEAR.
- IDLE: cnt_clr=0, cnt_en=0. start → CLEAR.
- CLEAR: cnt_clr=0, cnt_en=0, s1=s2=0. After CLR_CYCLES cycles → RUN.
- RUN: cnt_clr=1, cnt_en=1. Each cycle s1←cnt_val, s2←s1. stable = (s1==s2). If stable && s2 ≥ cmp_act (unsigned) → MATCH.
- MATCH (exactly one cycle): wakeup=1, irq set, match_cnt+1 (wraps to 0). Counter keeps running. Then per_act=1 → CLEAR, otherwise → DONE.
- DONE: cnt_clr=1, cnt_en=0; counter holds its value. start → CLEAR.
- stop in any non-IDLE state → IDLE. When start and stop are both high, stop wins.
- irq_ack clears irq and overrun. If a set from MATCH and irq_ack fall in the same cycle, the set wins.
- overrun is set on MATCH entry when irq is already 1.
- start in CLEAR/RUN/MATCH is ignored.
- cmp_act=0: match on the first RUN cycle, because the samples reset to 0.

## Timing
- Reset values: state=IDLE, cnt_clr=0, cnt_en=0, wakeup=0, irq=0, overrun=0, busy=0, match_cnt=0, cmp_act=cmp_pend=all-ones, per_act=per_pend=0, s1=s2=0.
- All outputs are registered or decoded from state only. No combinational path from input to output.
- start high in cycle N (IDLE): CLEAR from N+1 to N+CLR_CYCLES; RUN from N+1+CLR_CYCLES.
- Match latency: cnt_val first shows a value ≥ cmp in cycle k and holds it. s1 holds it in k+1, s2 in k+2, so stable is true in k+2. MATCH and wakeup occur in k+3.
- A cnt_val that differs between two consecutive samples never triggers a match.
- Periodic: MATCH in cycle M, CLEAR from M+1, RUN again at M+1+CLR_CYCLES.
- Reset asserted mid-operation: all state returns immediately to reset values, and cnt_clr goes low asynchronously.

## Test plan
- Reset: assert clr=0 mid-RUN → state=0, cnt_clr=0, cnt_en=0, irq=0, match_cnt=0 with no clock edge.
- One-shot: cmp=10, periodic=0, start; model counter increments every 4 clk → exactly one wakeup, 3 cycles after cnt_val=10 appears; then state=DONE, cnt_en=0, irq=1, match_cnt=1.
- Periodic with glitches: cmp=5, periodic=1; inject single-cycle cnt_val=31 glitches → no early match; matches every (5 counts + CLR_CYCLES + latency); second match with irq unacked → overrun=1; irq_ack → irq=overrun=0.
- Shadow config: in RUN, cfg_wr cmp=3 while cmp_act=100 → current period still matches at 100; next period matches at 3.
- Conflicts: start and stop high together in RUN → IDLE. MATCH and irq_ack in the same cycle → irq=1.
- Boundaries: cmp=0 → MATCH one cycle after RUN entry. cmp=0x1FFFF → match only at full count. 256 periodic matches → match_cnt wraps to 0.
